// File: rtl/sd_frame_sync.sv
// Serial frame synchroniser: hunts for the 1011 sync word, tracks lock over fixed-length frames
// and emits deframed payload words. Define SD_FSYNC_ERRCNT_EN to add the saturating err_cnt output.
module sd_frame_sync #(
  parameter int DATA_W   = 8,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signal,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              sync_err
`ifdef SD_FSYNC_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [3:0]    SYNC_WORD = 4'b1011;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [GW-1:0] LOCK_MAX  = GW'(LOCK_CNT);
  localparam logic [GW-1:0] LOCK_M1   = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] LOSS_M1   = MW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, SYNC_CHK} state_t;

  state_t            state;
  logic [2:0]        hist;
  logic [2:0]        sync_sr;
  logic [1:0]        sync_cnt;
  logic [DATA_W-2:0] payload;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     good_cnt;
  logic [MW-1:0]     miss_cnt;

  logic [3:0]        hist_nxt;
  logic [3:0]        sync_nxt;
  logic [DATA_W-1:0] payload_nxt;
  logic              sync_last;
  logic              sync_fail;

  assign hist_nxt    = {hist, signal};
  assign sync_nxt    = {sync_sr, signal};
  assign payload_nxt = {payload, signal};
  assign sync_last   = bit_en && (state == SYNC_CHK) && (sync_cnt == 2'd3);
  assign sync_fail   = sync_last && (sync_nxt != SYNC_WORD);

  // Shift registers carry only data and need no reset; every bit is overwritten before use.
  always_ff @(posedge clk) begin
    if (bit_en) begin
      if (state == PAYLOAD)  payload <= payload_nxt[DATA_W-2:0];
      if (state == SYNC_CHK) sync_sr <= sync_nxt[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      hist       <= '0;
      sync_cnt   <= '0;
      bit_cnt    <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (bit_en) begin
        case (state)
          HUNT: begin
            if (hist_nxt == SYNC_WORD) begin
              good_cnt <= GW'(1);
              bit_cnt  <= '0;
              hist     <= '0;
              state    <= PAYLOAD;
              if (LOCK_CNT == 1) locked <= 1'b1;
            end else begin
              hist <= hist_nxt[2:0];
            end
          end
          PAYLOAD: begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              sync_cnt <= '0;
              state    <= SYNC_CHK;
              if (locked) begin
                data_out   <= payload_nxt;
                data_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          SYNC_CHK: begin
            if (sync_cnt != 2'd3) begin
              sync_cnt <= sync_cnt + 1'b1;
            end else if (sync_nxt == SYNC_WORD) begin
              miss_cnt <= '0;
              bit_cnt  <= '0;
              state    <= PAYLOAD;
              if (good_cnt >= LOCK_M1) begin
                good_cnt <= LOCK_MAX;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else if (!locked) begin
              good_cnt <= '0;
              hist     <= '0;
              state    <= HUNT;
            end else begin
              sync_err <= 1'b1;
              // Flywheel over isolated misses; drop to HUNT only after LOSS_CNT in a row.
              if (miss_cnt >= LOSS_M1) begin
                locked   <= 1'b0;
                good_cnt <= '0;
                miss_cnt <= '0;
                hist     <= '0;
                state    <= HUNT;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
                bit_cnt  <= '0;
                state    <= PAYLOAD;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef SD_FSYNC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (sync_fail && locked && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/sd_frame_sync.md
# sd_frame_sync

Serial frame-synchronisation controller built around an overlapping 1011 sync detector. It hunts the serial stream for the 4-bit sync word 1011 and then sequences the detector through fixed-length frames, each made of the 1011 sync word followed by DATA_W payload bits. It acquires and tracks lock, flywheels over isolated sync errors, and hands deframed payload words to downstream logic. It sits between the serial bit receiver and the byte-level datapath.

## Interface
- DATA_W, 8, payload bits per frame (>=2)
- LOCK_CNT, 2, consecutive good syncs (including the hunt detection) needed to assert lock (>=1)
- LOSS_CNT, 2, consecutive bad syncs while locked that drop lock (>=1)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- signal  input  1  serial data bit, MSB of payload first
- bit_en  input  1  qualifies signal; all state advances only on cycles with bit_en=1
- data_out  output  DATA_W  last payload word; holds value between pulses
- data_valid  output  1  one-cycle pulse, data_out is new
- locked  output  1  frame lock status
- sync_err  output  1  one-cycle pulse on a failed sync check while locked

## Operation
- States: HUNT, PAYLOAD, SYNC_CHK.
- HUNT: 4-bit history of accepted bits; overlapping detection of 1011 (e.g. 1,0,1,0,1,1 detects on the 6th bit). On detect: good_cnt=1, bit_cnt=0, go to PAYLOAD. If LOCK_CNT=1, locked=1 at the same edge.
- Entering HUNT from any state clears the history, so no detection occurs until 4 new bits have been accepted.
- PAYLOAD: shift DATA_W bits into the payload register, MSB first. After the DATA_W-th bit, go to SYNC_CHK. If locked=1 at that edge: data_out is loaded and data_valid pulses.
- SYNC_CHK: collect 4 bits and compare them to 1011 after the 4th bit.
  - Match: good_cnt is incremented, saturating at LOCK_CNT; miss_cnt=0. If good_cnt reaches LOCK_CNT, locked=1. Go to PAYLOAD.
  - Mismatch, not locked: good_cnt=0, go to HUNT. No sync_err.
  - Mismatch, locked: sync_err pulses and miss_cnt is incremented.
    - If miss_cnt reaches LOSS_CNT: locked=0, good_cnt=0, miss_cnt=0, go to HUNT.
    - Otherwise stay locked and go to PAYLOAD (flywheel).
- Counter widths are $clog2(max+1). bit_cnt wraps at DATA_W.
- Reset values: state=HUNT, history=0, data_out=0, data_valid=0, locked=0, sync_err=0, all counters 0.

## Timing
- All outputs are registered and update on the rising clk edge that samples the relevant bit with bit_en=1.
- data_valid is high for exactly one clk cycle after the edge sampling the last payload bit, even if bit_en stays low afterwards.
- locked and sync_err change on the edge sampling the 4th sync bit.
- When lock is lost, sync_err and the falling edge of locked occur on the same edge, and the state is HUNT in the next cycle.
- With bit_en=0, all state, counters and data_out hold. Pulses still deassert after one cycle.
- Asserting rst at any point, including mid-frame, returns the block to HUNT immediately. An in-progress payload is discarded and no data_valid is produced.
- Minimum bit spacing is one clk (bit_en may be tied high).

## Configuration
- SD_FSYNC_ERRCNT_EN defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on every sync_err pulse and saturates at 255.
  - Cleared only by rst.
- Not defined: the err_cnt port and its counter do not exist; all other behaviour is identical.

## Test plan
All tests use DATA_W=8, LOCK_CNT=2, LOSS_CNT=2.

- Reset: pulse rst low mid-PAYLOAD -> all outputs 0, state HUNT; the next 1011 is needed before any progress.
- Overlapping hunt: bits 1,0,1,0,1,1 then 8 payload bits then 1011 -> detection on bit 6; locked rises on the 4th sync bit; no data_valid for the first payload.
- Acquisition and data: frames 1011+0xA5, 1011+0x3C, 1011+0x5A -> locked after the second sync; data_valid with data_out=0x3C, then 0x5A; 0xA5 is never output.
- Flywheel: while locked, send one sync as 1001 followed by payload 0x77 -> sync_err pulse, locked stays 1, data_out=0x77 is valid; the next good sync clears miss_cnt.
- Loss of lock: two consecutive bad syncs -> sync_err on each; locked falls with the second; no further data_valid until lock is reacquired. With SD_FSYNC_ERRCNT_EN, err_cnt=2.
- bit_en gaps: repeat the acquisition test with bit_en random at 30% duty -> identical data_out sequence; data_valid is one cycle wide each time.
